// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver with mid-bit sampling.
// rx is double-flopped before use; a received byte appears on data together
// with a one-clock irq strobe. Optional macro UART_RX_FRAME_ERR_EN adds a
// frame_err output that pulses when the stop-bit sample is low.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       irq
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic       frame_err
`endif
);

  localparam int BIT_CNT  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int TMR_W    = $clog2(BIT_CNT);
  localparam logic [TMR_W-1:0] BIT_END  = TMR_W'(BIT_CNT - 1);
  localparam logic [TMR_W-1:0] HALF_END = TMR_W'(HALF_CNT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t state, state_d;

  // rx_p0/rx_p1 form the synchronizer; rx_p2 is the previous synchronized
  // value so IDLE only arms on a genuine high-to-low transition.
  logic rx_p0, rx_p1, rx_p2;

  logic [TMR_W-1:0] tmr;
  logic [2:0]       idx;
  logic [7:0]       shift;

  logic tmr_clr, idx_clr, smp, load;
`ifdef UART_RX_FRAME_ERR_EN
  logic ferr;
`endif

  // Synchronize rx; flops preset to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state decode and per-cycle datapath controls.
  always_comb begin
    state_d = state;
    tmr_clr = 1'b0;
    idx_clr = 1'b0;
    smp     = 1'b0;
    load    = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    ferr    = 1'b0;
`endif
    case (state)
      IDLE: begin
        tmr_clr = 1'b1;
        // A line still low after a framing error must not retrigger.
        if (rx_p2 && !rx_p1) state_d = START;
      end
      START: begin
        if (tmr == HALF_END) begin
          tmr_clr = 1'b1;
          idx_clr = 1'b1;
          state_d = rx_p1 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tmr == BIT_END) begin
          tmr_clr = 1'b1;
          smp     = 1'b1;
          if (idx == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Leaving at mid stop bit leaves half a bit to catch the next start.
        if (tmr == BIT_END) begin
          tmr_clr = 1'b1;
          state_d = IDLE;
          if (rx_p1) load = 1'b1;
`ifdef UART_RX_FRAME_ERR_EN
          else       ferr = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit timer and bit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr <= '0;
      idx <= '0;
    end else begin
      tmr <= tmr_clr ? '0 : tmr + TMR_W'(1);
      if (idx_clr)  idx <= '0;
      else if (smp) idx <= idx + 3'd1;
    end
  end

  // Shift register: partial bytes are simply overwritten by the next frame.
  always_ff @(posedge clk) begin
    if (smp) shift[idx] <= rx_p1;
  end

  // Output register: data and irq update in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= 8'h00;
      irq  <= 1'b0;
    end else begin
      irq <= load;
      if (load) data <= shift;
    end
  end

`ifdef UART_RX_FRAME_ERR_EN
  // Framing-error strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_err <= 1'b0;
    else     frame_err <= ferr;
  end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven frames plus hand sequences for glitch and
// mid-frame reset; a monitor pops expected bytes on every irq pulse.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BIT_NS = 8680;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       irq;
`ifdef UART_RX_FRAME_ERR_EN
  logic       frame_err;
  int         ferr_cnt = 0;
`endif

  always #10 clk = ~clk;

  uart_rx #(.CLK_FREQ(50000000), .BAUD_RATE(115200)) dut (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .data (data),
    .irq  (irq)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .frame_err (frame_err)
`endif
  );

  int         n_checks  = 0;
  int         n_fail    = 0;
  int         pulse_cnt = 0;
  logic       irq_q     = 1'b0;
  logic [7:0] sb[$];

  typedef struct {
    logic [7:0] val;
    logic       stop;
    int         gap_bits;
    logic [7:0] exp_data;
    int         exp_pulses;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    #BIT_NS;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #BIT_NS;
    end
    rx = stop;
    #BIT_NS;
  endtask

  // Monitor: every irq must be one clock wide and match the next queued byte.
  always @(negedge clk) begin
    if (irq === 1'b1) begin
      pulse_cnt++;
      check("irq_width", 32'(irq_q), 32'h0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL irq_unexpected: got pulse with data 0x%0h, expected no pulse", data);
      end else begin
        check("rx_byte", 32'(data), 32'(sb.pop_front()));
      end
    end
`ifdef UART_RX_FRAME_ERR_EN
    if (frame_err === 1'b1) ferr_cnt++;
`endif
    irq_q = irq;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{val: 8'h9B, stop: 1'b1, gap_bits: 0, exp_data: 8'h9B, exp_pulses: 1, exp_ferr: 0};
    vecs[1] = '{val: 8'h80, stop: 1'b1, gap_bits: 2, exp_data: 8'h80, exp_pulses: 2, exp_ferr: 0};
    vecs[2] = '{val: 8'h55, stop: 1'b0, gap_bits: 2, exp_data: 8'h80, exp_pulses: 2, exp_ferr: 1};
    vecs[3] = '{val: 8'h3C, stop: 1'b1, gap_bits: 2, exp_data: 8'h3C, exp_pulses: 3, exp_ferr: 1};

    // Reset with idle line.
    #100;
    check("reset_data", 32'(data), 32'h00);
    check("reset_irq", 32'(irq), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #100us;
    check("idle_pulses", pulse_cnt, 0);
    check("idle_data", 32'(data), 32'h00);

    // Frame table; a zero gap makes the next frame back-to-back.
    for (int v = 0; v < 4; v++) begin
      if (vecs[v].stop) sb.push_back(vecs[v].val);
      send_frame(vecs[v].val, vecs[v].stop);
      check($sformatf("row%0d_data", v), 32'(data), 32'(vecs[v].exp_data));
      check($sformatf("row%0d_pulses", v), pulse_cnt, vecs[v].exp_pulses);
`ifdef UART_RX_FRAME_ERR_EN
      check($sformatf("row%0d_ferr", v), ferr_cnt, vecs[v].exp_ferr);
`endif
      rx = 1'b1;
      #(vecs[v].gap_bits * BIT_NS);
    end

    // Glitch shorter than half a bit.
    rx = 1'b0;
    #2000;
    rx = 1'b1;
    #(2 * BIT_NS);
    check("glitch_pulses", pulse_cnt, 3);
    check("glitch_data", 32'(data), 32'h3C);

    // Reset in the middle of data bit 3.
    rx = 1'b0;
    #BIT_NS;
    for (int i = 0; i < 3; i++) begin
      rx = 1'b1;
      #BIT_NS;
    end
    rx = 1'b0;
    #(BIT_NS / 2);
    rst = 1'b1;
    #1;
    check("midreset_data", 32'(data), 32'h00);
    check("midreset_irq", 32'(irq), 32'h0);
    #19;
    rx = 1'b1;
    #100;
    rst = 1'b0;
    #(2 * BIT_NS);
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    check("after_reset_data", 32'(data), 32'hA5);
    check("after_reset_pulses", pulse_cnt, 4);
    #(2 * BIT_NS);
    check("final_data_hold", 32'(data), 32'hA5);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver, 8N1 format: 1 start bit, 8 data bits LSB first, no parity, 1 stop bit.
- Oversamples the `rx` line with the system clock and delivers each received byte on a parallel `data` output.
- Flags each completed byte with a single-cycle `irq` pulse to the host-side logic (interrupt/FIFO write strobe).
- Sits between the board-level RX pin and the processor/peripheral bus.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD_RATE, 115200: serial bit rate in bit/s.
- BIT_CNT (derived localparam), CLK_FREQ/BAUD_RATE = 434: clocks per bit. Half-bit = BIT_CNT/2 = 217.

Ports:
- clk  input  1  system clock, 50 MHz nominal.
- rst  input  1  reset; asynchronous, active-high.
- rx  input  1  serial line; idle high; asynchronous to clk.
- data  output  8  last correctly received byte.
- irq  output  1  one-clk pulse when a new byte is valid on data.
- frame_err  output  1  present only with UART_RX_FRAME_ERR_EN.

Behaviour:
- Reset (rst=1, async): state IDLE, counters 0, data=8'h00, irq=0, synchronizer flops preset to 1 (line idle).
- Input sync: rx passes through a 2-flop synchronizer before any use. All decisions use the synchronized value.
- IDLE: wait for synchronized rx=0 (falling edge from idle), then go to START with bit timer cleared.
- START:
  - Count to half-bit (217 clocks) and resample.
  - If rx=1: false start; return to IDLE, no output change.
  - If rx=0: clear timer, bit index=0, go to DATA.
- DATA:
  - Every BIT_CNT clocks (i.e. mid-bit) sample rx into shift register position bit index (LSB first), then increment the index.
  - After the 8th sample, go to STOP.
- STOP:
  - After BIT_CNT clocks (mid stop bit), sample rx.
  - If rx=1: load data with the shift register and assert irq for exactly one clk in the same cycle. data and irq change together.
  - If rx=0 (framing error): data unchanged, no irq.
  - Either way return to IDLE. IDLE waits for rx=1 before re-arming, so a held-low line does not retrigger.
- Latency: irq rises about 9.5 bit times (≈4123 clks) after the start-bit falling edge, plus 2 synchronizer clocks.
- data holds its value until the next valid frame; it is never cleared except by reset.
- Back-to-back frames: a start bit immediately following the stop bit (no extra idle) must be received. IDLE is re-entered at mid stop bit, leaving half a bit of margin.
- Tolerance: sampling at mid-bit tolerates ±4% cumulative baud mismatch.
- rst asserted mid-frame: immediate abort to IDLE, outputs to reset values, partial byte discarded.
- Counter widths: bit timer sized for BIT_CNT-1 (9 bits at defaults). Bit index is 3 bits plus terminal detect.

Optional Feature:
- Macro UART_RX_FRAME_ERR_EN.
- Defined:
  - Output port frame_err exists.
  - It pulses high for one clk when the stop-bit sample is 0; irq stays 0 and data is unchanged for that frame.
  - Reset value 0.
- Undefined:
  - Port absent; framing errors are silently dropped.
  - All other behaviour identical.

Test Plan:
- Reset: hold rst=1 with rx=1, then release -> data=8'h00, irq=0, no pulse during 100 µs of idle.
- Single frame at 8680 ns/bit: start, bits 1,1,0,1,1,0,0,1, stop=1 -> one irq pulse of exactly 20 ns, data=8'h9B at the pulse, held afterwards.
- Back-to-back frame directly after the previous stop: start, bits 0,0,0,0,0,0,0,1, stop=1 -> second irq pulse, data=8'h80, exactly two pulses in total.
- Glitch: rx low for 2 µs (< half bit) then high -> no irq, data unchanged.
- Framing error: valid start, data 8'h55, stop=0 -> no irq, data unchanged; frame_err pulses once when the macro is defined.
- Mid-frame reset: assert rst during data bit 3 of a frame -> data=8'h00 and irq=0 immediately; the next clean frame 8'hA5 is received correctly.
